relu_maxpool2x2_stream: RTL and testbench
=========================================

// Module: relu_maxpool2x2_stream
// PURPOSE
//  Downstream stage of one featuremap_conv2d_* filter: consumes its raster-order fp32 output stream,
//  applies ReLU, then 2x2/stride-2 max pooling. Emits one pooled fp32 value per 2x2 window, in raster order.
//  One instance per conv filter. Result feeds the next layer's per-channel input FIFO.
// PARAMETERS
//  DATA_WIDTH  32   word width, IEEE-754 single
//  WIDTH       112  pixels per input row (even; conv output width)
//  HEIGHT      112  rows per input frame (even)
// PORTS
//  clk         in   1           clock
//  rst         in   1           synchronous reset, active-high
//  valid_in    in   1           data_in valid (driven by the conv stage's valid_out)
//  data_in     in   DATA_WIDTH  conv+bias result, fp32
//  valid_out   out  1           data_out valid, one-cycle pulse per pooled value
//  data_out    out  DATA_WIDTH  pooled fp32 value (always >= +0)
//  frame_last  out  1           high together with valid_out on the last pooled value of a frame
// BEHAVIOUR
//  - One clock; rst is synchronous and active-high. On rst: valid_out=0, data_out=0, frame_last=0, col=0,
//    row=0, row phase=EVEN, h_reg=0. Line-buffer contents are don't-care (always rewritten before use).
//  - Pixel counting: state advances only on cycles with valid_in=1. Gaps of any length are allowed; no backpressure.
//  - col counts 0..WIDTH-1, wraps to 0 and increments row. row counts 0..HEIGHT-1, wraps to 0 (next frame
//    follows with no idle cycle needed).
//  - ReLU: r = data_in[31] ? 0 : data_in. Sign bit set, including -0 and negative NaN, gives 0. Positive NaN/Inf pass.
//  - Compare: after ReLU all values have sign 0, so max() is an unsigned compare of the 31-bit pattern.
//    No FP unit is used. Ties select either (identical value).
//  - Horizontal pair: col even -> h_reg <= r. col odd -> hmax = max(h_reg, r) (combinational).
//  - Row-phase FSM (2 states):
//      EVEN: on odd col, line_buf[col>>1] <= hmax. At col=WIDTH-1, go to ODD.
//      ODD:  on odd col, the pooled value is max(line_buf[col>>1], hmax). It is registered:
//            valid_out=1 and data_out=pooled on the NEXT clock. At col=WIDTH-1, go to EVEN.
//  - Line buffer: WIDTH/2 x DATA_WIDTH, 1 write port + 1 read port. Read is combinational or pre-fetched,
//    but must meet the 1-cycle latency above.
//  - Latency: 1 cycle from the accepting edge of the 2nd pixel of the window's bottom row to valid_out.
//  - valid_out is low in every other cycle. data_out holds its last value while valid_out=0.
//  - frame_last=1 only with the output produced at row=HEIGHT-1, col=WIDTH-1. Otherwise 0.
//  - Outputs per frame = (WIDTH/2)*(HEIGHT/2). Throughput: at most 1 output per 2 input beats.
//  - Reset mid-frame (rst wins over a simultaneous valid_in): the partial frame is discarded.
//    No output from the old window appears after the reset edge. The next valid_in is treated as row 0, col 0.
//  - Elaboration: WIDTH and HEIGHT must be even and >=2. Odd values are a compile-time error via a generate check.
// TESTING (bench uses WIDTH=4, HEIGHT=4)
//  1 Reset: hold rst 3 cycles with valid_in=1, data=0x40400000 -> valid_out=0, data_out=0, frame_last=0 throughout.
//  2 Window values: row0 = 1.0,2.0,-1.0,0.5 (3F800000,40000000,BF800000,3F000000);
//    row1 = 0.5,3.0,-2.0,-3.0 -> 40400000 one cycle after row1 px1, then 3F000000 one cycle after row1 px3.
//  3 All-negative and -0 window (BF800000,80000000,C0000000,BF000000) -> data_out=00000000 with valid_out=1.
//  4 Bubbles: repeat test 2 with valid_in low for random 0-5 cycles between beats -> identical outputs and order.
//    Each output comes exactly 1 cycle after its trigger beat.
//  5 Two back-to-back 4x4 frames, pixel value = index as fp32 (0.0..15.0) -> 4 outputs per frame:
//    40A00000, 40E00000, 41500000, 41700000. frame_last only on the 4th and 8th outputs.
//  6 Assert rst for 1 cycle mid-row1 of a frame, then send a fresh frame -> no stale output.
//    Fresh frame results match test 5.

Source files
------------

// File: rtl/relu_maxpool2x2_stream.sv
// ReLU followed by 2x2/stride-2 max pooling on a raster-order fp32 stream.
// One pooled value is emitted per window, one cycle after its last pixel.
module relu_maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_last
);

    localparam int HALF   = WIDTH / 2;
    localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int ADDR_W = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2 ||
            (HEIGHT % 2) != 0 || HEIGHT < 2) begin : g_bad_geometry
            $error("WIDTH and HEIGHT must be even and >= 2");
        end
    endgenerate

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    phase_t phase_q;
    phase_t phase_d;

    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic [DATA_WIDTH-1:0] h_reg;
    logic [DATA_WIDTH-1:0] line_buf [HALF];

    logic                  col_last;
    logic                  row_last;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] relu_v;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] lb_rd;
    logic [DATA_WIDTH-1:0] pooled;
    logic                  lb_we;
    logic                  pool_fire;

    assign col_last = (col_q == COL_W'(WIDTH - 1));
    assign row_last = (row_q == ROW_W'(HEIGHT - 1));
    assign addr     = ADDR_W'(col_q >> 1);

    // Sign bit set covers -0 and negative NaN; all survivors compare as unsigned.
    assign relu_v = data_in[DATA_WIDTH-1] ? '0 : data_in;
    assign hmax   = (relu_v > h_reg) ? relu_v : h_reg;
    assign lb_rd  = line_buf[addr];
    assign pooled = (hmax > lb_rd) ? hmax : lb_rd;

    always_comb begin
        phase_d   = phase_q;
        lb_we     = 1'b0;
        pool_fire = 1'b0;
        if (valid_in) begin
            unique case (phase_q)
                PH_EVEN: begin
                    lb_we = col_q[0];
                    if (col_last) phase_d = PH_ODD;
                end
                PH_ODD: begin
                    pool_fire = col_q[0];
                    if (col_last) phase_d = PH_EVEN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_EVEN;
            col_q      <= '0;
            row_q      <= '0;
            h_reg      <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            frame_last <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            valid_out  <= pool_fire;
            frame_last <= pool_fire && row_last && col_last;
            if (pool_fire) data_out <= pooled;
            if (valid_in) begin
                if (!col_q[0]) h_reg <= relu_v;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    // Contents need no reset: every entry is rewritten on an even row before use.
    always_ff @(posedge clk) begin
        if (lb_we && !rst) line_buf[addr] <= hmax;
    end

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// Randomised bench for relu_maxpool2x2_stream against a frame-array window model.
// Inputs change and outputs are sampled on the falling edge.
module tb_relu_maxpool2x2_stream;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic        frame_last;

    relu_maxpool2x2_stream #(
        .DATA_WIDTH(32),
        .WIDTH(W),
        .HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .data_in(data_in),
        .valid_out(valid_out),
        .data_out(data_out),
        .frame_last(frame_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int          m_row = 0;
    int          m_col = 0;
    logic [31:0] m_pix [H][W];
    logic [31:0] m_last = 32'h0;
    logic [31:0] idx_tab [4];

    logic [31:0] win_tab [8] = '{32'h3F800000, 32'h40000000,
                                 32'hBF800000, 32'h3F000000,
                                 32'h3F000000, 32'h40400000,
                                 32'hC0000000, 32'hC0400000};

    function automatic logic [31:0] relu(input logic [31:0] d);
        return d[31] ? 32'h0 : d;
    endfunction

    function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [31:0] itof(input int i);
        int e;
        logic [31:0] m;
        if (i == 0) return 32'h0;
        e = 0;
        while ((i >> (e + 1)) != 0) e++;
        m = 32'(i) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    // Drive one cycle (called at a falling edge) and predict the outputs after it.
    task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                         output logic ev, output logic ef, output logic [31:0] ed);
        rst = r;
        valid_in = v;
        data_in = d;
        ev = 1'b0;
        ef = 1'b0;
        if (r) begin
            m_row = 0;
            m_col = 0;
            m_last = 32'h0;
        end else if (v) begin
            m_pix[m_row][m_col] = relu(d);
            if ((m_row % 2) == 1 && (m_col % 2) == 1) begin
                ev = 1'b1;
                m_last = umax(umax(m_pix[m_row-1][m_col-1], m_pix[m_row-1][m_col]),
                              umax(m_pix[m_row][m_col-1], m_pix[m_row][m_col]));
                ef = (m_row == H - 1) && (m_col == W - 1);
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        ed = m_last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic ev, ef;
        logic [31:0] ed;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 32'h40400000, ev, ef, ed);
            n_vec++;
            if ({valid_out, frame_last, data_out} !== {1'b0, 1'b0, 32'h0}) begin
                n_err++;
                $display("FAIL reset[%0d]: got v=%b fl=%b d=%h, want v=0 fl=0 d=00000000",
                         i, valid_out, frame_last, data_out);
            end
        end
    endtask

    task automatic test_window();
        logic ev, ef;
        logic [31:0] ed;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, win_tab[i], ev, ef, ed);
            n_vec++;
            if ({valid_out, frame_last, data_out} !== {ev, ef, ed}) begin
                n_err++;
                $display("FAIL window[%0d]: got v=%b fl=%b d=%h, want v=%b fl=%b d=%h",
                         i, valid_out, frame_last, data_out, ev, ef, ed);
            end
            if (i == 5 || i == 7) begin
                n_vec++;
                if ({valid_out, data_out} !== {1'b1, (i == 5) ? 32'h40400000 : 32'h3F000000}) begin
                    n_err++;
                    $display("FAIL window_value[%0d]: got v=%b d=%h", i, valid_out, data_out);
                end
            end
        end
    endtask

    task automatic test_negative();
        logic ev, ef;
        logic [31:0] ed;
        logic [31:0] px;
        for (int i = 0; i < 8; i++) begin
            unique case (i)
                0: px = 32'hBF800000;
                1: px = 32'h80000000;
                4: px = 32'hC0000000;
                5: px = 32'hBF000000;
                default: px = $urandom;
            endcase
            cycle(1'b0, 1'b1, px, ev, ef, ed);
            n_vec++;
            if ({valid_out, frame_last, data_out} !== {ev, ef, ed}) begin
                n_err++;
                $display("FAIL negative[%0d]: got v=%b fl=%b d=%h, want v=%b fl=%b d=%h",
                         i, valid_out, frame_last, data_out, ev, ef, ed);
            end
            if (i == 5) begin
                n_vec++;
                if ({valid_out, data_out} !== {1'b1, 32'h0}) begin
                    n_err++;
                    $display("FAIL negative_zero: got v=%b d=%h, want v=1 d=00000000",
                             valid_out, data_out);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        logic ev, ef;
        logic [31:0] ed;
        logic [31:0] px;
        int gap;
        for (int i = 0; i < 16; i++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 1'b0, $urandom, ev, ef, ed);
                n_vec++;
                if ({valid_out, frame_last, data_out} !== {ev, ef, ed}) begin
                    n_err++;
                    $display("FAIL bubble_gap[%0d]: got v=%b fl=%b d=%h, want v=%b fl=%b d=%h",
                             i, valid_out, frame_last, data_out, ev, ef, ed);
                end
            end
            px = (i < 8) ? win_tab[i] : $urandom;
            cycle(1'b0, 1'b1, px, ev, ef, ed);
            n_vec++;
            if ({valid_out, frame_last, data_out} !== {ev, ef, ed}) begin
                n_err++;
                $display("FAIL bubble_beat[%0d]: got v=%b fl=%b d=%h, want v=%b fl=%b d=%h",
                         i, valid_out, frame_last, data_out, ev, ef, ed);
            end
            if (i == 5 || i == 7) begin
                n_vec++;
                if ({valid_out, data_out} !== {1'b1, (i == 5) ? 32'h40400000 : 32'h3F000000}) begin
                    n_err++;
                    $display("FAIL bubble_value[%0d]: got v=%b d=%h", i, valid_out, data_out);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ev, ef;
        logic [31:0] ed;
        logic [31:0] got [8];
        logic        fl [8];
        int k = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                cycle(1'b0, 1'b1, itof(i), ev, ef, ed);
                n_vec++;
                if ({valid_out, frame_last, data_out} !== {ev, ef, ed}) begin
                    n_err++;
                    $display("FAIL b2b[%0d.%0d]: got v=%b fl=%b d=%h, want v=%b fl=%b d=%h",
                             f, i, valid_out, frame_last, data_out, ev, ef, ed);
                end
                if (valid_out === 1'b1 && k < 8) begin
                    got[k] = data_out;
                    fl[k] = frame_last;
                    k++;
                end
            end
        end
        n_vec++;
        if (k != 8) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs, want 8", k);
        end
        for (int j = 0; j < k; j++) begin
            n_vec++;
            if ({fl[j], got[j]} !== {(j % 4) == 3, idx_tab[j % 4]}) begin
                n_err++;
                $display("FAIL b2b_out[%0d]: got fl=%b d=%h, want fl=%b d=%h",
                         j, fl[j], got[j], (j % 4) == 3, idx_tab[j % 4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ev, ef;
        logic [31:0] ed;
        logic [31:0] got [4];
        int k = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, $urandom, ev, ef, ed);
            n_vec++;
            if ({valid_out, frame_last, data_out} !== {ev, ef, ed}) begin
                n_err++;
                $display("FAIL midrst_pre[%0d]: got v=%b fl=%b d=%h, want v=%b fl=%b d=%h",
                         i, valid_out, frame_last, data_out, ev, ef, ed);
            end
        end
        cycle(1'b1, 1'b1, 32'h7F000000, ev, ef, ed);
        n_vec++;
        if ({valid_out, frame_last, data_out} !== {1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL midrst_edge: got v=%b fl=%b d=%h, want v=0 fl=0 d=00000000",
                     valid_out, frame_last, data_out);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, itof(i), ev, ef, ed);
            n_vec++;
            if ({valid_out, frame_last, data_out} !== {ev, ef, ed}) begin
                n_err++;
                $display("FAIL midrst_frame[%0d]: got v=%b fl=%b d=%h, want v=%b fl=%b d=%h",
                         i, valid_out, frame_last, data_out, ev, ef, ed);
            end
            if (valid_out === 1'b1 && k < 4) begin
                got[k] = data_out;
                k++;
            end
        end
        n_vec++;
        if (k != 4) begin
            n_err++;
            $display("FAIL midrst_count: got %0d outputs, want 4", k);
        end
        for (int j = 0; j < k; j++) begin
            n_vec++;
            if (got[j] !== idx_tab[j]) begin
                n_err++;
                $display("FAIL midrst_out[%0d]: got %h, want %h", j, got[j], idx_tab[j]);
            end
        end
    endtask

    initial begin
        idx_tab[0] = 32'h40A00000;
        idx_tab[1] = 32'h40E00000;
        idx_tab[2] = 32'h41500000;
        idx_tab[3] = 32'h41700000;
        test_reset();
        test_window();
        test_negative();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
